// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the register file with scoreboard.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_NREAD = 2;

endpackage

// File: rtl/regfile_scoreboard.sv
// Write-pending scoreboard: one bit per register, set on lock, released on writeback.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             lock,
    input  logic [AW-1:0]    lockaddr,
    input  logic             we,
    input  logic [AW-1:0]    writeaddr,
    output logic [DEPTH-1:0] pending
);

    logic lock_ok;
    logic release_ok;

    assign lock_ok    = lock && !(ZERO_REG && (lockaddr == '0));
    assign release_ok = we && !(ZERO_REG && (writeaddr == '0));

    // The set is applied after the clear so a new producer wins a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
        end else if (run) begin
            if (release_ok) pending[writeaddr] <= 1'b0;
            if (lock_ok)    pending[lockaddr]  <= 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass, pending scoreboard and post-reset clear sweep.
//   state | meaning
//   CLEAR | sweeping zeros into every entry, outputs forced to 0, writes/locks dropped
//   RUN   | normal operation, ready = 1
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NREAD    = DEF_NREAD,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   ready,
    input  logic                   we,
    input  logic [AW-1:0]          writeaddr,
    input  logic [WIDTH-1:0]       writedata,
    input  logic                   lock,
    input  logic [AW-1:0]          lockaddr,
    input  logic [NREAD*AW-1:0]    readaddr,
    output logic [NREAD*WIDTH-1:0] readdata,
    output logic [NREAD-1:0]       readbusy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t           state;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] pending;
    logic             run;
    logic             wr_ok;

    assign run   = (state == RUN);
    assign wr_ok = run && we && !(ZERO_REG && (writeaddr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
            idx   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    idx <= idx + AW'(1);
                    if (idx == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= CLEAR;
                    idx   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    // Storage has no reset of its own; the sweep is what clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) mem[idx] <= '0;
            else if (wr_ok)     mem[writeaddr] <= writedata;
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .lock      (lock),
        .lockaddr  (lockaddr),
        .we        (we),
        .writeaddr (writeaddr),
        .pending   (pending)
    );

    for (genvar p = 0; p < NREAD; p++) begin : g_read
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;
        logic             busy;

        assign ra = readaddr[p*AW +: AW];

        always_comb begin
            rd   = '0;
            busy = 1'b0;
            if (!run) begin
                rd   = '0;
                busy = 1'b0;
            end else if (ZERO_REG && (ra == '0)) begin
                rd   = '0;
                busy = 1'b0;
            end else if (we && (ra == writeaddr)) begin
                rd   = writedata;
                busy = 1'b0;
            end else begin
                rd   = mem[ra];
                busy = pending[ra];
            end
        end

        assign readdata[p*WIDTH +: WIDTH] = rd;
        assign readbusy[p]                = busy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: 32x32/2-port with and without zero register, plus 8-entry/3-port.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        we = 1'b0;
    logic [4:0]  writeaddr = '0;
    logic [31:0] writedata = '0;
    logic        lock = 1'b0;
    logic [4:0]  lockaddr = '0;
    logic [9:0]  readaddr = '0;
    logic        ready_a, ready_b;
    logic [63:0] readdata_a, readdata_b;
    logic [1:0]  readbusy_a, readbusy_b;

    logic        we_c = 1'b0;
    logic [2:0]  writeaddr_c = '0;
    logic [31:0] writedata_c = '0;
    logic        lock_c = 1'b0;
    logic [2:0]  lockaddr_c = '0;
    logic [8:0]  readaddr_c = '0;
    logic        ready_c;
    logic [95:0] readdata_c;
    logic [2:0]  readbusy_c;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst(rst), .ready(ready_a),
        .we(we), .writeaddr(writeaddr), .writedata(writedata),
        .lock(lock), .lockaddr(lockaddr),
        .readaddr(readaddr), .readdata(readdata_a), .readbusy(readbusy_a)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ready(ready_b),
        .we(we), .writeaddr(writeaddr), .writedata(writedata),
        .lock(lock), .lockaddr(lockaddr),
        .readaddr(readaddr), .readdata(readdata_b), .readbusy(readbusy_b)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(8), .NREAD(3), .ZERO_REG(1'b1)) dut_c (
        .clk(clk), .rst(rst), .ready(ready_c),
        .we(we_c), .writeaddr(writeaddr_c), .writedata(writedata_c),
        .lock(lock_c), .lockaddr(lockaddr_c),
        .readaddr(readaddr_c), .readdata(readdata_c), .readbusy(readbusy_c)
    );

    // Counts negedges after rst release until ready; 0 means the bound expired.
    task automatic wait_ready(output int na, output int nc);
        na = 0;
        nc = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (n == 6)  begin we_c = 1'b0; lock_c = 1'b0; end
            if (n == 12) begin we = 1'b0; lock = 1'b0; end
            if (nc == 0 && ready_c) nc = n;
            if (ready_a) begin
                na = n;
                break;
            end
        end
        we = 1'b0; lock = 1'b0; we_c = 1'b0; lock_c = 1'b0;
    endtask

    task automatic test_reset();
        int na, nc;
        @(negedge clk);
        rst = 1'b1;
        readaddr = {5'd3, 5'd17};
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0 || ready_c !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ready: got a=%b b=%b c=%b, expected 0", ready_a, ready_b, ready_c);
        end
        tests_run++;
        if (readdata_a !== 64'h0 || readbusy_a !== 2'b00 || readdata_c !== 96'h0 || readbusy_c !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rd_a=%h rb_a=%b rd_c=%h rb_c=%b, expected all 0",
                     readdata_a, readbusy_a, readdata_c, readbusy_c);
        end
        @(negedge clk);
        rst = 1'b0;
        we = 1'b1; writeaddr = 5'd2; writedata = 32'h5555AAAA;
        lock = 1'b1; lockaddr = 5'd3;
        we_c = 1'b1; writeaddr_c = 3'd2; writedata_c = 32'h5555AAAA;
        lock_c = 1'b1; lockaddr_c = 3'd3;
        wait_ready(na, nc);
        tests_run++;
        if (na !== 32 || ready_b !== 1'b1) begin
            tests_failed++;
            $display("FAIL sweep_len_32: got %0d cycles (ready_b=%b), expected 32", na, ready_b);
        end
        tests_run++;
        if (nc !== 8) begin
            tests_failed++;
            $display("FAIL sweep_len_8: got %0d cycles, expected 8", nc);
        end
        @(negedge clk);
        readaddr = {5'd3, 5'd2};
        readaddr_c = {3'd0, 3'd3, 3'd2};
        #1;
        tests_run++;
        if (readdata_a !== 64'h0 || readbusy_a !== 2'b00 || readdata_b !== 64'h0 || readbusy_b !== 2'b00) begin
            tests_failed++;
            $display("FAIL clear_ignores_req: got rd_a=%h rb_a=%b rd_b=%h rb_b=%b, expected 0",
                     readdata_a, readbusy_a, readdata_b, readbusy_b);
        end
        tests_run++;
        if (readdata_c !== 96'h0 || readbusy_c !== 3'b000) begin
            tests_failed++;
            $display("FAIL clear_ignores_req_c: got rd=%h rb=%b, expected 0", readdata_c, readbusy_c);
        end
    endtask

    task automatic test_sweep_clear();
        int na, nc;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            we = 1'b1; writeaddr = 5'(i); writedata = 32'hA5A50000 | i;
            lock = 1'b1; lockaddr = 5'(i) ^ 5'd16;
            we_c = (i < 8); writeaddr_c = 3'(i); writedata_c = 32'hC0DE0000 | i;
        end
        @(negedge clk);
        we = 1'b0; lock = 1'b0; we_c = 1'b0;
        readaddr = {5'd7, 5'd0};
        #1;
        tests_run++;
        if (readdata_b !== {32'hA5A50007, 32'hA5A50000} || readbusy_b !== 2'b11) begin
            tests_failed++;
            $display("FAIL junk_b: got rd=%h rb=%b, expected a5a50007a5a50000 rb=11", readdata_b, readbusy_b);
        end
        tests_run++;
        if (readdata_a !== {32'hA5A50007, 32'h0} || readbusy_a !== 2'b10) begin
            tests_failed++;
            $display("FAIL junk_a: got rd=%h rb=%b, expected a5a5000700000000 rb=10", readdata_a, readbusy_a);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        tests_run++;
        if (readdata_b !== 64'h0 || readbusy_b !== 2'b00 || ready_b !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_in_run: got rd=%h rb=%b ready=%b, expected 0", readdata_b, readbusy_b, ready_b);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_ready(na, nc);
        tests_run++;
        if (na !== 32 || nc !== 8) begin
            tests_failed++;
            $display("FAIL sweep_len_rerun: got %0d/%0d cycles, expected 32/8", na, nc);
        end
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            readaddr = {5'(31 - i), 5'(i)};
            readaddr_c = {3'(i), 3'(i), 3'(i)};
            #1;
            tests_run++;
            if (readdata_a !== 64'h0 || readbusy_a !== 2'b00 || readdata_b !== 64'h0 || readbusy_b !== 2'b00) begin
                tests_failed++;
                $display("FAIL swept_%0d: got rd_a=%h rb_a=%b rd_b=%h rb_b=%b, expected 0",
                         i, readdata_a, readbusy_a, readdata_b, readbusy_b);
            end
            if (i < 8) begin
                tests_run++;
                if (readdata_c !== 96'h0 || readbusy_c !== 3'b000) begin
                    tests_failed++;
                    $display("FAIL swept_c_%0d: got rd=%h rb=%b, expected 0", i, readdata_c, readbusy_c);
                end
            end
        end
    endtask

    task automatic test_mid_sweep();
        int na, nc;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        tests_run++;
        if (ready_a !== 1'b0 || ready_c !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_sweep_state: got ready_a=%b ready_c=%b, expected 0/1", ready_a, ready_c);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_ready(na, nc);
        tests_run++;
        if (na !== 32 || nc !== 8) begin
            tests_failed++;
            $display("FAIL mid_sweep_restart: got %0d/%0d cycles, expected 32/8", na, nc);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        we = 1'b1; writeaddr = 5'd5; writedata = 32'hDEADBEEF;
        readaddr = {5'd5, 5'd5};
        #1;
        tests_run++;
        if (readdata_a !== {2{32'hDEADBEEF}} || readbusy_a !== 2'b00 || readdata_b !== {2{32'hDEADBEEF}}) begin
            tests_failed++;
            $display("FAIL bypass: got rd_a=%h rb_a=%b rd_b=%h, expected deadbeef x2", readdata_a, readbusy_a, readdata_b);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        tests_run++;
        if (readdata_a !== {2{32'hDEADBEEF}} || readbusy_a !== 2'b00) begin
            tests_failed++;
            $display("FAIL stored: got rd=%h rb=%b, expected deadbeef x2", readdata_a, readbusy_a);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        lock = 1'b1; lockaddr = 5'd7;
        readaddr = {5'd5, 5'd7};
        #1;
        tests_run++;
        if (readbusy_a !== 2'b00) begin
            tests_failed++;
            $display("FAIL lock_same_cycle: got rb=%b, expected 00", readbusy_a);
        end
        @(negedge clk);
        lock = 1'b0;
        #1;
        tests_run++;
        if (readbusy_a !== 2'b01 || readdata_a !== {32'hDEADBEEF, 32'h0}) begin
            tests_failed++;
            $display("FAIL lock_t1: got rd=%h rb=%b, expected deadbeef00000000 rb=01", readdata_a, readbusy_a);
        end
        @(negedge clk);
        #1;
        tests_run++;
        if (readbusy_a !== 2'b01) begin
            tests_failed++;
            $display("FAIL lock_t2: got rb=%b, expected 01", readbusy_a);
        end
        @(negedge clk);
        we = 1'b1; writeaddr = 5'd7; writedata = 32'h00001234;
        #1;
        tests_run++;
        if (readbusy_a !== 2'b00 || readdata_a[31:0] !== 32'h00001234) begin
            tests_failed++;
            $display("FAIL release_bypass: got rd=%h rb=%b, expected 00001234 rb=00", readdata_a[31:0], readbusy_a);
        end
        @(negedge clk);
        we = 1'b0;
        #1;
        tests_run++;
        if (readbusy_a !== 2'b00 || readdata_a[31:0] !== 32'h00001234) begin
            tests_failed++;
            $display("FAIL release_stored: got rd=%h rb=%b, expected 00001234 rb=00", readdata_a[31:0], readbusy_a);
        end
    endtask

    task automatic test_collision();
        @(negedge clk);
        lock = 1'b1; lockaddr = 5'd9;
        we = 1'b1; writeaddr = 5'd9; writedata = 32'hCAFE0009;
        readaddr = {5'd9, 5'd9};
        #1;
        tests_run++;
        if (readdata_a !== {2{32'hCAFE0009}} || readbusy_a !== 2'b00) begin
            tests_failed++;
            $display("FAIL collide_now: got rd=%h rb=%b, expected cafe0009 x2 rb=00", readdata_a, readbusy_a);
        end
        @(negedge clk);
        lock = 1'b0; we = 1'b0;
        #1;
        tests_run++;
        if (readdata_a !== {2{32'hCAFE0009}} || readbusy_a !== 2'b11) begin
            tests_failed++;
            $display("FAIL collide_next: got rd=%h rb=%b, expected cafe0009 x2 rb=11", readdata_a, readbusy_a);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        lock = 1'b1; lockaddr = 5'd0;
        we = 1'b1; writeaddr = 5'd0; writedata = 32'hFFFFFFFF;
        readaddr = {5'd5, 5'd0};
        #1;
        tests_run++;
        if (readdata_a[31:0] !== 32'h0 || readbusy_a[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_bypass_a: got rd=%h rb=%b, expected 0/0", readdata_a[31:0], readbusy_a[0]);
        end
        tests_run++;
        if (readdata_b[31:0] !== 32'hFFFFFFFF || readbusy_b[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_bypass_b: got rd=%h rb=%b, expected ffffffff/0", readdata_b[31:0], readbusy_b[0]);
        end
        @(negedge clk);
        lock = 1'b0; we = 1'b0;
        #1;
        tests_run++;
        if (readdata_a !== {32'hDEADBEEF, 32'h0} || readbusy_a !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_after_a: got rd=%h rb=%b, expected deadbeef00000000 rb=00", readdata_a, readbusy_a);
        end
        tests_run++;
        if (readdata_b !== {32'hDEADBEEF, 32'hFFFFFFFF} || readbusy_b !== 2'b01) begin
            tests_failed++;
            $display("FAIL zero_after_b: got rd=%h rb=%b, expected deadbeefffffffff rb=01", readdata_b, readbusy_b);
        end
    endtask

    task automatic test_three_ports();
        @(negedge clk);
        we_c = 1'b1; writeaddr_c = 3'd3; writedata_c = 32'h11;
        @(negedge clk);
        writeaddr_c = 3'd5; writedata_c = 32'h22;
        @(negedge clk);
        we_c = 1'b0; lock_c = 1'b1; lockaddr_c = 3'd6;
        @(negedge clk);
        lock_c = 1'b0;
        readaddr_c = {3'd6, 3'd5, 3'd3};
        #1;
        tests_run++;
        if (readdata_c !== {32'h0, 32'h22, 32'h11} || readbusy_c !== 3'b100) begin
            tests_failed++;
            $display("FAIL ports_distinct: got rd=%h rb=%b, expected 000000000000002200000011 rb=100", readdata_c, readbusy_c);
        end
        @(negedge clk);
        readaddr_c = {3'd5, 3'd5, 3'd5};
        #1;
        tests_run++;
        if (readdata_c !== {3{32'h22}} || readbusy_c !== 3'b000) begin
            tests_failed++;
            $display("FAIL ports_same: got rd=%h rb=%b, expected 00000022 x3 rb=000", readdata_c, readbusy_c);
        end
        @(negedge clk);
        we_c = 1'b1; writeaddr_c = 3'd6; writedata_c = 32'h33;
        readaddr_c = {3'd0, 3'd6, 3'd3};
        #1;
        tests_run++;
        if (readdata_c !== {32'h0, 32'h33, 32'h11} || readbusy_c !== 3'b000) begin
            tests_failed++;
            $display("FAIL ports_bypass: got rd=%h rb=%b, expected 000000000000003300000011 rb=000", readdata_c, readbusy_c);
        end
        @(negedge clk);
        we_c = 1'b0;
        readaddr_c = {3'd6, 3'd6, 3'd0};
        #1;
        tests_run++;
        if (readdata_c !== {32'h33, 32'h33, 32'h0} || readbusy_c !== 3'b000) begin
            tests_failed++;
            $display("FAIL ports_after: got rd=%h rb=%b, expected 000000330000003300000000 rb=000", readdata_c, readbusy_c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_sweep_clear();
        test_mid_sweep();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_zero_reg();
        test_three_ports();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port register file with a built-in write-pending scoreboard and a hardware clear sweep after reset. It replaces the fixed 32x32 two-read-port file in the pipelined core. Decode gets operand data and a per-operand "busy" flag in the same cycle. Writeback data forwards combinationally to readers, and the scoreboard bit for that register is released in the same cycle.

## Interface
Parameters:
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (power of two, >= 2); AW = $clog2(DEPTH)
- NREAD, 2, number of independent read ports (>= 1)
- ZERO_REG, 1, if 1 then entry 0 reads as 0, ignores writes and can never be locked

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- ready  out  1  high when the clear sweep is done and the file accepts writes and locks
- we  in  1  write enable (writeback)
- writeaddr  in  AW  write address
- writedata  in  WIDTH  write data
- lock  in  1  mark register lockaddr as pending (issue of a producer)
- lockaddr  in  AW  register to lock
- readaddr  in  NREAD x AW  read addresses
- readdata  out  NREAD x WIDTH  read data, combinational
- readbusy  out  NREAD x 1  pending flag for each read port, combinational

## Operation
- FSM states are CLEAR and RUN.
- rst forces CLEAR with sweep index 0 and clears all pending bits.
- CLEAR:
  - Each cycle writes 0 to mem[index], then increments index.
  - The cycle that writes index DEPTH-1 moves the FSM to RUN.
  - we and lock are ignored.
  - readdata = 0 and readbusy = 0 on all ports.
  - ready = 0.
- RUN, write: we stores writedata to mem[writeaddr] and clears pending[writeaddr].
- RUN, lock: lock sets pending[lockaddr].
- Same-cycle lock and we to the same address: pending ends set. The new producer wins; the data is still written.
- Read port p, priority order:
  1. If ZERO_REG and readaddr[p] == 0: data 0, busy 0.
  2. Else if we and readaddr[p] == writeaddr: data = writedata, busy 0 (bypass).
  3. Else: data = mem[readaddr[p]], busy = pending[readaddr[p]].
- A lock in the current cycle does not affect readbusy until the next cycle.
- ZERO_REG = 1: writes and locks to address 0 are dropped.
- ZERO_REG = 0: entry 0 is an ordinary register.
- All read ports are fully independent. Any ports may read the same address.
- rst asserted mid-sweep or during RUN restarts the sweep at index 0.

## Timing
- Reset values: ready = 0, readdata = 0, readbusy = 0, pending = 0.
- Clear sweep:
  - Lasts exactly DEPTH cycles after the first clk edge with rst low.
  - ready rises after edge DEPTH (counting the first rst-low edge as 1).
- Write to read: 0-cycle latency through bypass. The stored value is visible from the next cycle.
- Lock to readbusy: 1 cycle.
- Writeback to busy release: 0 cycles, via bypass.
- No handshake. Callers must not issue we or lock while ready = 0; such requests are lost by design.

## Structure
- Package regfile_pkg:
  - state_t enum {CLEAR, RUN}
  - default localparams for WIDTH, DEPTH, NREAD
- Sub-module regfile_scoreboard:
  - Holds the DEPTH-bit pending vector.
  - Inputs: rst, run, lock/lockaddr, we/writeaddr, ZERO_REG.
  - Outputs the pending vector; the top level indexes it per read port.
- Top level: storage array, sweep counter/FSM, NREAD replicated read muxes.

## Test plan
- Clear sweep: rst for 2 cycles, then release; mem preloaded with junk via backdoor → ready = 0 for exactly 32 cycles, then 1; every readaddr 0..31 returns 0.
- Bypass and write: we = 1, writeaddr = 5, writedata = 0xDEADBEEF, readaddr[0] = readaddr[1] = 5 → both ports read 0xDEADBEEF the same cycle; with we = 0 the next cycle, still 0xDEADBEEF.
- Scoreboard: lock reg 7 at cycle t → readbusy = 1 at t+1; we to 7 with 0x1234 at t+3 → readbusy = 0 and data 0x1234 at t+3.
- Lock/write collision: lock and we both to reg 9 in one cycle → next cycle readbusy = 1 and readdata = written value.
- Zero register: with ZERO_REG = 1, lock 0 and write 0xFFFFFFFF to 0 → readdata 0, readbusy 0; repeat with ZERO_REG = 0 → reads 0xFFFFFFFF.
- Reset mid-sweep: assert rst at sweep index 10 → ready stays 0 for a full 32 cycles after release. Repeat with DEPTH = 8, NREAD = 3 → 8-cycle sweep, 3 independent ports.
